// File: rtl/tile_row_fetcher.sv
// rtl/tile_row_fetcher.sv - scanline tile-index fetcher with ping-pong line buffer
// Reads one map row from a 1-cycle-latency RAM per line_start; renderer reads the other buffer.
module tile_row_fetcher #(
    parameter int A     = 16,
    parameter int D     = 16,
    parameter int COLS  = 40,
    parameter int MAP_W = 64,
    parameter int BASE  = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         line_start,
    input  logic [5:0]   tile_row,
    input  logic [5:0]   scroll_col,
    output logic [A-1:0] ram_addr,
    input  logic [D-1:0] ram_dout,
    input  logic [5:0]   rd_col,
    output logic [D-1:0] rd_tile,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int         ROW_SH   = $clog2(MAP_W);
    localparam logic [5:0] COL_MASK = 6'(MAP_W - 1);
    localparam logic [5:0] LAST_IC  = 6'(COLS - 1);
    localparam logic [6:0] N_COLS   = 7'(COLS);

    logic [1:0]   r_state;
    logic         r_front;
    logic         r_valid;
    logic [5:0]   r_row;
    logic [5:0]   r_scroll;
    logic [5:0]   r_ic;
    logic         r_cap;
    logic [5:0]   r_wc;
    logic [A-1:0] r_ram_addr;
    logic [D-1:0] r_rd_tile;
    logic         r_busy;
    logic         r_done;
    logic         r_overrun;
    logic [D-1:0] r_buf [2][COLS];

    // Column wraps within the map row so a scrolled fetch never spills into the next row.
    function automatic logic [A-1:0] map_addr(input logic [5:0] row, input logic [5:0] scol,
                                              input logic [5:0] ic);
        logic [5:0] col;
        col = (scol + ic) & COL_MASK;
        return A'(BASE) + (A'(row) << ROW_SH) + A'(col);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_front    <= 1'b0;
            r_valid    <= 1'b0;
            r_row      <= '0;
            r_scroll   <= '0;
            r_ic       <= '0;
            r_cap      <= 1'b0;
            r_wc       <= '0;
            r_ram_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_cap     <= 1'b0;
            if (line_start) begin
                // valid is only ever set in IDLE, so an aborted fetch can never swap.
                if (r_valid)
                    r_front <= ~r_front;
                r_overrun  <= (r_state != S_IDLE);
                r_valid    <= 1'b0;
                r_row      <= tile_row;
                r_scroll   <= scroll_col;
                r_ic       <= '0;
                r_ram_addr <= map_addr(tile_row, scroll_col, 6'd0);
                r_busy     <= 1'b1;
                r_state    <= S_ISSUE;
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        r_cap <= 1'b1;
                        r_wc  <= r_ic;
                        if (r_ic == LAST_IC) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_ic       <= r_ic + 6'd1;
                            r_ram_addr <= map_addr(r_row, r_scroll, r_ic + 6'd1);
                        end
                    end
                    S_DRAIN: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // A capture landing on a new line_start belongs to the aborted fetch and is dropped.
    always_ff @(posedge clk) begin
        if (!reset && r_cap && !line_start)
            r_buf[~r_front][r_wc] <= ram_dout;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_rd_tile <= '0;
        else if ({1'b0, rd_col} < N_COLS)
            r_rd_tile <= r_buf[r_front][rd_col];
        else
            r_rd_tile <= '0;
    end

    assign ram_addr = r_ram_addr;
    assign rd_tile  = r_rd_tile;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule
